// File: rtl/datalink_pkg.sv
// Shared types and default constants for the open-drain data link transceiver.
package datalink_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BIT_TICKS    = 4;
  localparam int DEF_RESP_TIMEOUT = 64;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    DONE
  } state_t;

  // Counter width able to hold the given terminal value without wrapping.
  function automatic int cnt_width(input int term);
    return $clog2(term) + 1;
  endfunction

endpackage

// File: rtl/datalink_if.sv
// Host-side control and status bundle for the data link transceiver.
interface datalink_if import datalink_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              Locked;
  logic              trig_in;
  logic [DATA_W-1:0] tx_data;
  logic              status;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              err_timeout;
  logic              err_frame;

  modport master (
    output Locked, trig_in, tx_data,
    input  status, rx_data, rx_valid, err_timeout, err_frame
  );

  modport slave (
    input  Locked, trig_in, tx_data,
    output status, rx_data, rx_valid, err_timeout, err_frame
  );

endinterface

// File: rtl/datalink_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module datalink_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/datalink_xcvr.sv
// Half-duplex open-drain transceiver: sends one frame per trigger, then
// receives the responder's frame on the same line.
//
// state    | meaning
// IDLE     | line released, waiting for a qualified trigger edge
// TX_START | driving the start cell low
// TX_DATA  | driving payload cells, LSB first
// TX_STOP  | released stop cell
// RX_WAIT  | waiting for the responder's start bit, timeout running
// RX_START | counting to mid start cell and checking it is low
// RX_DATA  | sampling payload cells at mid-cell
// RX_STOP  | checking the stop cell is high at mid-cell
// DONE     | rx_valid pulse, back to IDLE next cycle
module datalink_xcvr import datalink_pkg::*; #(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BIT_TICKS    = DEF_BIT_TICKS,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic       clk_50khz,
  input  logic       rst,
  datalink_if.slave  bus,
  inout  wire        datalink
);

  localparam int TICK_W = cnt_width(BIT_TICKS);
  localparam int BIT_W  = cnt_width(DATA_W);
  localparam int TO_W   = cnt_width(RESP_TIMEOUT);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(BIT_TICKS / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RESP_TIMEOUT - 1);

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [BIT_W-1:0]    r_bit;
  logic [TO_W-1:0]     r_to;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [DATA_W-1:0]   r_rx_shift;
  logic                r_drive_low;
  logic                r_trig_prev;
  logic [1:0]          r_warm;
  logic                r_status;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_err_timeout;
  logic                r_err_frame;

  logic                w_trig_s;
  logic                w_line_s;
  logic                w_trig_edge;
  logic                w_tick_done;
  logic [DATA_W-1:0]   w_rx_shift_next;

  datalink_sync u_sync_trig (
    .clk (clk_50khz),
    .rst (rst),
    .i_d (bus.trig_in),
    .o_q (w_trig_s)
  );

  datalink_sync u_sync_line (
    .clk (clk_50khz),
    .rst (rst),
    .i_d (datalink),
    .o_q (w_line_s)
  );

  // Edges only count once the edge register holds a real synchronised
  // sample, so a trigger held high across reset release is not taken.
  assign w_trig_edge     = w_trig_s & ~r_trig_prev & (r_warm == 2'd3);
  assign w_tick_done     = (r_tick == '0);
  assign w_rx_shift_next = (r_rx_shift >> 1) | (DATA_W'(w_line_s) << (DATA_W - 1));

  assign datalink        = r_drive_low ? 1'b0 : 1'bz;
  assign bus.status      = r_status;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_frame   = r_err_frame;

  // Trigger edge history and post-reset warm-up of the edge detector.
  always_ff @(posedge clk_50khz or posedge rst) begin
    if (rst) begin
      r_trig_prev <= 1'b0;
      r_warm      <= 2'd0;
    end else begin
      r_trig_prev <= w_trig_s;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Transaction sequencer with registered line drive and status outputs.
  always_ff @(posedge clk_50khz or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_bit         <= '0;
      r_to          <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_drive_low   <= 1'b0;
      r_status      <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_frame   <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_frame   <= 1'b0;
      if (r_state != IDLE && !bus.Locked) begin
        r_state     <= IDLE;
        r_drive_low <= 1'b0;
        r_status    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_drive_low <= 1'b0;
            if (w_trig_edge && bus.Locked) begin
              r_tx_shift  <= bus.tx_data;
              r_status    <= 1'b1;
              r_drive_low <= 1'b1;
              r_tick      <= TICK_LAST;
              r_state     <= TX_START;
            end
          end
          TX_START: begin
            if (w_tick_done) begin
              r_drive_low <= ~r_tx_shift[0];
              r_tx_shift  <= r_tx_shift >> 1;
              r_tick      <= TICK_LAST;
              r_bit       <= BIT_LAST;
              r_state     <= TX_DATA;
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          TX_DATA: begin
            if (w_tick_done) begin
              r_tick <= TICK_LAST;
              if (r_bit == '0) begin
                r_drive_low <= 1'b0;
                r_state     <= TX_STOP;
              end else begin
                r_drive_low <= ~r_tx_shift[0];
                r_tx_shift  <= r_tx_shift >> 1;
                r_bit       <= r_bit - BIT_W'(1);
              end
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          TX_STOP: begin
            if (w_tick_done) begin
              r_to    <= TO_LAST;
              r_state <= RX_WAIT;
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          RX_WAIT: begin
            if (!w_line_s) begin
              r_tick  <= TICK_HALF;
              r_state <= RX_START;
            end else if (r_to == '0) begin
              r_err_timeout <= 1'b1;
              r_status      <= 1'b0;
              r_state       <= IDLE;
            end else begin
              r_to <= r_to - TO_W'(1);
            end
          end
          RX_START: begin
            if (w_tick_done) begin
              if (!w_line_s) begin
                r_tick  <= TICK_LAST;
                r_bit   <= BIT_LAST;
                r_state <= RX_DATA;
              end else begin
                r_err_frame <= 1'b1;
                r_status    <= 1'b0;
                r_state     <= IDLE;
              end
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          RX_DATA: begin
            if (w_tick_done) begin
              r_rx_shift <= w_rx_shift_next;
              r_tick     <= TICK_LAST;
              if (r_bit == '0) r_state <= RX_STOP;
              else             r_bit   <= r_bit - BIT_W'(1);
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          RX_STOP: begin
            if (w_tick_done) begin
              if (w_line_s) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_state    <= DONE;
              end else begin
                r_err_frame <= 1'b1;
                r_status    <= 1'b0;
                r_state     <= IDLE;
              end
            end else begin
              r_tick <= r_tick - TICK_W'(1);
            end
          end
          DONE: begin
            r_status <= 1'b0;
            r_state  <= IDLE;
          end
          default: begin
            r_drive_low <= 1'b0;
            r_status    <= 1'b0;
            r_state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
